// File: rtl/xor_accum_pipe.sv
// xor_accum_pipe: per-lane XOR/XNOR/accumulate unit feeding a small result FIFO
//   clk, reset            : sole clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake (beat carries in_a, in_b, in_op)
//   in_op                 : 00 XOR, 01 XNOR, 10 acc^X, 11 load X into acc
//   acc_clear             : zero the accumulator (before an accepted op 10)
//   out_comb              : combinational in_a ^ in_b
//   out_valid/out_ready   : output handshake on the queue head
//   out_data, out_parity  : queue head result and its per-lane parity
//   acc, beat_count       : accumulator register and accepted-beat counter
module xor_accum_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [1:0]             in_op,
  input  logic                   acc_clear,
  output logic [LANES*WIDTH-1:0] out_comb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_parity,
  output logic [LANES*WIDTH-1:0] acc,
  output logic [CNT_W-1:0]       beat_count
);
  localparam int W  = LANES * WIDTH;
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [W-1:0]  x, res;
  logic          push, pop;
  assign x        = in_a ^ in_b;
  assign out_comb = x;
  // Clear-before-accumulate: with acc_clear the op 10 result collapses to X.
  always_comb begin
    res = x;
    res = in_op == 2'b01 ? ~x :
          in_op == 2'b10 ? (acc_clear ? x : acc ^ x) : x;
  end
  // DEPTH is a power of two, so the occupancy MSB alone flags full.
  assign in_ready  = !count[PW] && !reset;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Gate the head so stale entries never show once the queue is empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  for (genvar i = 0; i < LANES; i++) begin : g_par
    assign out_parity[i] = ^out_data[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= res;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc        <= '0;
      beat_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) beat_count <= beat_count + CNT_W'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push && in_op[1]) acc <= res;
      else if (acc_clear) acc <= '0;
    end
  end
endmodule

// File: doc/xor_accum_pipe.md
XOR_ACCUM_PIPE -- requirements
Module: xor_accum_pipe

Interface
REQ-001 Parameter WIDTH, default 8, lane bit width (>=1).
REQ-002 Parameter LANES, default 4, number of independent lanes (>=1).
REQ-003 Parameter DEPTH, default 2, output queue entries (power of two, >=2).
REQ-004 Parameter CNT_W, default 8, beat counter width (>=1).
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  input beat offered.
REQ-009 in_ready  out  1  block accepts the beat this cycle.
REQ-010 in_a  in  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH].
REQ-011 in_b  in  LANES*WIDTH  operand B, same lane packing.
REQ-012 in_op  in  2  operation: 00 XOR, 01 XNOR, 10 accumulate, 11 load-accumulate.
REQ-013 acc_clear  in  1  clear accumulator.
REQ-014 out_comb  out  LANES*WIDTH  combinational in_a ^ in_b, independent of valid/ready.
REQ-015 out_valid  out  1  queue head valid.
REQ-016 out_ready  in  1  consumer accepts head.
REQ-017 out_data  out  LANES*WIDTH  queue head result.
REQ-018 out_parity  out  LANES  bit i = XOR-reduction of out_data lane i.
REQ-019 acc  out  LANES*WIDTH  current accumulator register.
REQ-020 beat_count  out  CNT_W  accepted input beats, modulo 2^CNT_W.

Function
REQ-021 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-022 in_ready SHALL equal (occupancy < DEPTH) && !reset; no pass-through when full, even if out_ready=1.
REQ-023 out_valid SHALL equal (occupancy != 0).
REQ-024 Result per lane, X = a ^ b: op 00 -> X; op 01 -> ~X; op 10 -> acc ^ X; op 11 -> X.
REQ-025 On accept with op 10 or 11, acc SHALL become the pushed result; ops 00/01 leave acc unchanged.
REQ-026 acc_clear without an accepted op 10/11 beat SHALL set acc to 0 next cycle.
REQ-027 acc_clear together with an accepted op 10 beat SHALL clear first, so result and new acc = X.
REQ-028 acc_clear together with an accepted op 11 beat SHALL give result and new acc = X.
REQ-029 Latency: an accept into an empty queue SHALL give out_valid=1 on the next cycle, with out_data equal to that beat's result.
REQ-030 Queue SHALL be FIFO ordered; simultaneous accept and pop SHALL keep occupancy unchanged.
REQ-031 Pop with no accept SHALL decrement occupancy; accept with no pop SHALL increment it.
REQ-032 When full, a pop SHALL free one entry visible as in_ready=1 on the following cycle.
REQ-033 out_data SHALL hold stable while out_valid && !out_ready.
REQ-034 beat_count SHALL increment by 1 per accept and wrap from 2^CNT_W-1 to 0.
REQ-035 Lanes SHALL be bitwise independent; no carries between lanes.
REQ-036 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-037 While reset=1 at a clock edge, occupancy, queue pointers, acc and beat_count SHALL become 0.
REQ-038 During reset, in_ready SHALL be 0 and no accept SHALL be counted.
REQ-039 After reset: out_valid=0, out_parity=0, acc=0, beat_count=0; in_ready=1 in the first cycle with reset=0.
REQ-040 Reset mid-operation SHALL discard all queued results, with no partial pop.
REQ-041 out_comb SHALL follow inputs regardless of reset.

Verification (WIDTH=8, LANES=2, DEPTH=2, CNT_W=3)
REQ-042 Op 00, a=0x0F_A5, b=0xFF_5A, out_ready=1 -> out_comb=0xF0_FF at once; out_data=0xF0_FF and out_parity=2'b00 next cycle.
REQ-043 Op 11 with X=0x01_01, then op 10 with X=0x03_02 -> results 0x01_01 then 0x02_03; acc=0x02_03.
REQ-044 acc_clear with accepted op 10 X=0x10_20 while acc=0xFF_FF -> result=acc=0x10_20.
REQ-045 out_ready=0, three beats offered -> two accepted, in_ready=0; one pop -> third accepted next cycle; order preserved.
REQ-046 Nine accepts -> beat_count reaches 7, then wraps to 0, then reads 1.
REQ-047 Reset asserted with 2 entries queued -> next cycle out_valid=0, acc=0, beat_count=0; no stale data after release.
